// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler: per-warp phase encoding and default warp count.
// Phase codes are shared by the FSM register and the warp_state broadcast.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package warp_scheduler_pkg;

    localparam int DEFAULT_NUM_WARPS = `NUM_WARPS;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_FETCH   = 3'd1;
    localparam logic [2:0] PH_DECODE  = 3'd2;
    localparam logic [2:0] PH_REQUEST = 3'd3;
    localparam logic [2:0] PH_WAIT    = 3'd4;
    localparam logic [2:0] PH_EXECUTE = 3'd5;
    localparam logic [2:0] PH_UPDATE  = 3'd6;
    localparam logic [2:0] PH_DONE    = 3'd7;

endpackage

// File: rtl/warp_scheduler_rr.sv
// Round-robin pick of the next runnable warp after the current one.
// The current warp is examined last, so a lone survivor is re-selected.
module rr_next_warp #(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = 2
) (
    input  logic [NUM_WARPS-1:0]     runnable,
    input  logic [WARP_ID_WIDTH-1:0] current,
    output logic [WARP_ID_WIDTH-1:0] next_warp,
    output logic                     found
);

    logic [WARP_ID_WIDTH-1:0] cand;

    always_comb begin
        cand      = '0;
        next_warp = current;
        found     = 1'b0;
        for (int off = 1; off <= NUM_WARPS; off++) begin
            cand = WARP_ID_WIDTH'((int'(current) + off) % NUM_WARPS);
            if (!found && runnable[cand]) begin
                found     = 1'b1;
                next_warp = cand;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Single-issue round-robin warp scheduler: steps one warp at a time through
// fetch/decode/request/wait/execute/update and flags completion when all retire.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = DEFAULT_NUM_WARPS,
    parameter int WARP_ID_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WARP_ID_WIDTH:0]   num_warps_active,
    output logic                     fetch_req,
    input  logic                     fetch_ready,
    input  logic                     decoded_ret,
    input  logic                     decoded_mem_op,
    input  logic                     lsu_done,
    output logic [NUM_WARPS-1:0]     warp_enable,
    output warp_state_t              warp_state,
    output logic [WARP_ID_WIDTH-1:0] current_warp,
    output logic                     done
);

    logic [2:0]               phase_reg, phase_next;
    logic [NUM_WARPS-1:0]     runnable_reg, runnable_next;
    logic [NUM_WARPS-1:0]     retire_mask, launch_mask, enable_next;
    logic [WARP_ID_WIDTH-1:0] current_warp_reg, current_warp_next, rr_warp;
    logic [WARP_ID_WIDTH:0]   launch_count;
    logic [NUM_WARPS-1:0]     warp_enable_reg;
    logic                     rr_found, busy_next;
    logic                     ret_q_reg, mem_q_reg, fetch_req_reg, done_reg;

    assign launch_count = (num_warps_active > (WARP_ID_WIDTH+1)'(NUM_WARPS))
                        ? (WARP_ID_WIDTH+1)'(NUM_WARPS) : num_warps_active;
    assign busy_next    = (phase_next != PH_IDLE) && (phase_next != PH_DONE);

    // Per-warp masks: launch prefix, runnable set after a possible retire, and next enable.
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
        assign launch_mask[gi] = ((WARP_ID_WIDTH+1)'(gi) < launch_count);
        assign retire_mask[gi] = runnable_reg[gi]
                               & ~(ret_q_reg && (current_warp_reg == WARP_ID_WIDTH'(gi)));
        assign enable_next[gi] = busy_next && (current_warp_next == WARP_ID_WIDTH'(gi));
    end

    rr_next_warp #(
        .NUM_WARPS     (NUM_WARPS),
        .WARP_ID_WIDTH (WARP_ID_WIDTH)
    ) u_rr (
        .runnable  (retire_mask),
        .current   (current_warp_reg),
        .next_warp (rr_warp),
        .found     (rr_found)
    );

    always_comb begin
        phase_next        = phase_reg;
        runnable_next     = runnable_reg;
        current_warp_next = current_warp_reg;
        case (phase_reg)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    runnable_next     = launch_mask;
                    current_warp_next = '0;
                    phase_next        = (launch_count == '0) ? PH_DONE : PH_FETCH;
                end
            end
            PH_FETCH:   if (fetch_ready) phase_next = PH_DECODE;
            PH_DECODE:  phase_next = PH_REQUEST;
            PH_REQUEST: phase_next = PH_WAIT;
            PH_WAIT:    if (!mem_q_reg || lsu_done) phase_next = PH_EXECUTE;
            PH_EXECUTE: phase_next = PH_UPDATE;
            PH_UPDATE: begin
                runnable_next = retire_mask;
                if (rr_found) begin
                    current_warp_next = rr_warp;
                    phase_next        = PH_FETCH;
                end else begin
                    phase_next = PH_DONE;
                end
            end
            default:    phase_next = PH_IDLE;
        endcase
    end

    // Outputs are registered from next-state so nothing combinational reaches a port.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg        <= PH_IDLE;
            runnable_reg     <= '0;
            current_warp_reg <= '0;
            ret_q_reg        <= 1'b0;
            mem_q_reg        <= 1'b0;
            fetch_req_reg    <= 1'b0;
            done_reg         <= 1'b0;
            warp_enable_reg  <= '0;
        end else begin
            phase_reg        <= phase_next;
            runnable_reg     <= runnable_next;
            current_warp_reg <= current_warp_next;
            if (phase_reg == PH_DECODE) begin
                ret_q_reg <= decoded_ret;
                mem_q_reg <= decoded_mem_op;
            end
            fetch_req_reg    <= (phase_next == PH_FETCH);
            done_reg         <= (phase_next == PH_DONE);
            warp_enable_reg  <= enable_next;
        end
    end

    assign fetch_req    = fetch_req_reg;
    assign done         = done_reg;
    assign warp_enable  = warp_enable_reg;
    assign current_warp = current_warp_reg;
    assign warp_state   = warp_state_t'(phase_reg);

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: stimulus queues expected UPDATE/done events,
// a monitor pops and compares them as the DUT presents them.
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    localparam int NW = 4;
    localparam int WW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [WW:0]       num_warps_active = '0;
    logic              fetch_ready = 1'b0;
    logic              decoded_ret = 1'b0;
    logic              decoded_mem_op = 1'b0;
    logic              lsu_done = 1'b0;
    logic              fetch_req;
    logic [NW-1:0]     warp_enable;
    warp_state_t       warp_state;
    logic [WW-1:0]     current_warp;
    logic              done;

    warp_scheduler #(.NUM_WARPS(NW), .WARP_ID_WIDTH(WW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_warps_active (num_warps_active),
        .fetch_req        (fetch_req),
        .fetch_ready      (fetch_ready),
        .decoded_ret      (decoded_ret),
        .decoded_mem_op   (decoded_mem_op),
        .lsu_done         (lsu_done),
        .warp_enable      (warp_enable),
        .warp_state       (warp_state),
        .current_warp     (current_warp),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_done;
        int warp;
        int cycle;
    } exp_t;
    exp_t exp_q[$];

    // Program model: per-warp RET / load instruction numbers (1-based, 0 = never).
    int ret_at[NW];
    int mem_at[NW];
    int fetch_delay = 0;
    int lsu_wait = 0;
    bit stray_en = 1'b0;
    int ord_q[$];
    int len_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Responder: instruction memory, decoder and LSU reacting to the broadcast phase.
    initial begin : driver
        int inst_cnt[NW];
        int fetch_cnt;
        int wait_cnt;
        fetch_cnt = 0;
        wait_cnt = 0;
        for (int i = 0; i < NW; i++) inst_cnt[i] = 0;
        forever begin
            @(negedge clk);
            fetch_ready = 1'b0;
            decoded_ret = 1'b0;
            decoded_mem_op = 1'b0;
            lsu_done = 1'b0;
            if (reset || (start && (warp_state == WARP_IDLE || warp_state == WARP_DONE))) begin
                for (int i = 0; i < NW; i++) inst_cnt[i] = 0;
                fetch_cnt = 0;
                wait_cnt = 0;
            end else begin
                case (warp_state)
                    WARP_FETCH: begin
                        fetch_ready = (fetch_cnt == fetch_delay);
                        fetch_cnt++;
                    end
                    WARP_DECODE: begin
                        decoded_ret    = (inst_cnt[current_warp] + 1 == ret_at[current_warp]);
                        decoded_mem_op = (inst_cnt[current_warp] + 1 == mem_at[current_warp]);
                    end
                    WARP_WAIT: begin
                        lsu_done = (wait_cnt == lsu_wait);
                        wait_cnt++;
                    end
                    WARP_EXECUTE: lsu_done = stray_en;
                    WARP_UPDATE:  inst_cnt[current_warp]++;
                    default: ;
                endcase
                if (warp_state != WARP_FETCH) fetch_cnt = 0;
                if (warp_state != WARP_WAIT) wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        bit prev_done;
        bit is_upd;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            is_upd = (warp_state == WARP_UPDATE);
            if (is_upd || (done && !prev_done)) begin
                $display("txn cycle=%0d kind=%s warp=%0d enable=%b", cyc,
                         is_upd ? "update" : "done", current_warp, warp_enable);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", is_upd ? 0 : 1, e.is_done ? 1 : 0);
                    if (!e.is_done) begin
                        chk("update_warp", current_warp, e.warp);
                        chk("update_enable", warp_enable, 1 << e.warp);
                        chk("update_cycle", cyc, e.cycle);
                    end else begin
                        chk("done_cycle", cyc, e.cycle);
                        chk("done_enable", warp_enable, 0);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic launch(input int n, input bit expect_it);
        int t;
        exp_t e;
        @(posedge clk); #1;
        num_warps_active = (WW+1)'(n);
        start = 1'b1;
        t = cyc;
        if (expect_it) begin
            for (int i = 0; i < ord_q.size(); i++) begin
                t += len_q[i];
                e.is_done = 1'b0; e.warp = ord_q[i]; e.cycle = t;
                exp_q.push_back(e);
            end
            e.is_done = 1'b1; e.warp = 0; e.cycle = t + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_for(input warp_state_t s, input int w, input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (warp_state == s && current_warp == w) break;
        end
        if (i == 200) chk(name, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, warp_state, WARP_IDLE);
        chk({tag, "_enable"}, warp_enable, 0);
        chk({tag, "_fetch_req"}, fetch_req, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_current_warp"}, current_warp, 0);
    endtask

    task automatic set_prog(input int r0, input int r1, input int r2, input int r3,
                            input int m0, input int m1);
        ret_at[0] = r0; ret_at[1] = r1; ret_at[2] = r2; ret_at[3] = r3;
        mem_at[0] = m0; mem_at[1] = m1; mem_at[2] = 0;  mem_at[3] = 0;
    endtask

    initial begin : stimulus
        int fr;
        set_prog(1, 1, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Zero warps: straight to DONE one cycle after start.
        ord_q = {}; len_q = {};
        launch(0, 1'b1);
        wait_drain("n0_drain");

        // Three warps, RET on each warp's second instruction.
        set_prog(2, 2, 2, 2, 0, 0);
        ord_q = {0, 1, 2, 0, 1, 2}; len_q = {6, 6, 6, 6, 6, 6};
        launch(3, 1'b1);
        wait_drain("rr3_drain");

        // Warp 1 load with lsu_done low for 5 WAIT cycles; stray pulses in EXECUTE.
        set_prog(1, 1, 1, 1, 0, 1);
        lsu_wait = 5; stray_en = 1'b1;
        ord_q = {0, 1}; len_q = {6, 11};
        launch(2, 1'b1);
        wait_for(WARP_WAIT, 1, "mem_wait_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("wait_hold_state", warp_state, WARP_WAIT);
            chk("wait_hold_enable", warp_enable, 4'b0010);
            if (k < 4) @(negedge clk);
        end
        wait_drain("mem_drain");
        lsu_wait = 0; stray_en = 1'b0;

        // fetch_ready three cycles late.
        set_prog(1, 1, 1, 1, 0, 0);
        fetch_delay = 3;
        ord_q = {0}; len_q = {9};
        launch(1, 1'b1);
        fr = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_req) fr++;
            if (done) break;
        end
        chk("fetch_req_cycles", fr, 4);
        wait_drain("fetch_drain");
        fetch_delay = 0;

        // Warps 0 and 2 retire at once; warp 1 reissues back-to-back.
        set_prog(1, 4, 1, 1, 0, 0);
        ord_q = {0, 1, 2, 1, 1, 1}; len_q = {6, 6, 6, 6, 6, 6};
        launch(3, 1'b1);
        wait_drain("survivor_drain");

        // Seven clamps to four; a start during EXECUTE must be ignored.
        set_prog(1, 1, 1, 1, 0, 0);
        ord_q = {0, 1, 2, 3}; len_q = {6, 6, 6, 6};
        launch(7, 1'b1);
        wait_for(WARP_WAIT, 0, "clamp_wait_timeout");
        @(posedge clk); #1;
        num_warps_active = (WW+1)'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain("clamp_drain");

        // Reset while a load is pending, then relaunch from warp 0.
        set_prog(1, 1, 1, 1, 1, 0);
        lsu_wait = 20;
        launch(2, 1'b0);
        wait_for(WARP_WAIT, 0, "abort_wait_timeout");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        set_prog(1, 1, 1, 1, 0, 0);
        lsu_wait = 0;
        ord_q = {0, 1}; len_q = {6, 6};
        launch(2, 1'b1);
        wait_drain("replay_drain");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Single-issue warp scheduler for the lock-in core. It sequences one warp at a time through the per-instruction phases that each warp's scalar register file and datapath key off: fetch, decode, operand request, wait, execute and writeback. It shares the one fetch/ALU/LSU path between up to `NUM_WARPS` warps in round-robin order, retires warps on RET, and signals kernel completion. It sits between the kernel launch logic and the per-warp register files, driving their `enable` and `warp_state` inputs.

## Interface
- `NUM_WARPS`, default 4: number of warp contexts, range 1..32.
- `WARP_ID_WIDTH`, default `$clog2(NUM_WARPS)` (minimum 1): width of warp index.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  kernel launch pulse; honoured only in IDLE or DONE.
- `num_warps_active`  in  WARP_ID_WIDTH+1  warps to run this launch; values above `NUM_WARPS` clamp to `NUM_WARPS`.
- `fetch_req`  out  1  instruction fetch request for `current_warp`.
- `fetch_ready`  in  1  instruction memory returned the instruction.
- `decoded_ret`  in  1  decoded instruction is RET; valid during DECODE.
- `decoded_mem_op`  in  1  decoded instruction is a load or store; valid during DECODE.
- `lsu_done`  in  1  LSU completed the outstanding access.
- `warp_enable`  out  NUM_WARPS  one-hot enable to the per-warp register files.
- `warp_state`  out  warp_state_t  phase broadcast to the enabled warp.
- `current_warp`  out  WARP_ID_WIDTH  index of the issuing warp.
- `done`  out  1  all launched warps retired.

## Operation
- Phase FSM: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
- Register `runnable[NUM_WARPS]`.
- IDLE or DONE with `start`:
  - Set `runnable[i]=1` for i < clamped `num_warps_active`; clear all other bits.
  - Clear `done`.
  - If no warp is runnable, go to DONE. Otherwise go to FETCH with `current_warp` = lowest runnable index.
- FETCH: `fetch_req`=1 every cycle until `fetch_ready`; go to DECODE on the cycle after `fetch_ready` is seen.
- DECODE (1 cycle): latch `decoded_ret` into `ret_q` and `decoded_mem_op` into `mem_q`.
- REQUEST (1 cycle): the warp's register file captures rs1 and rs2.
- WAIT:
  - If `mem_q`=0: 1 cycle.
  - If `mem_q`=1: hold until `lsu_done` is sampled high in WAIT. `lsu_done` outside WAIT is ignored.
- EXECUTE (1 cycle), then UPDATE (1 cycle; register writeback happens here).
- Leaving UPDATE:
  - If `ret_q`=1, clear `runnable[current_warp]`.
  - Next warp is the first runnable index strictly after `current_warp`, wrapping modulo `NUM_WARPS`. The current warp is eligible last, so a sole remaining warp reissues.
  - If none is runnable, go to DONE; otherwise go to FETCH with the new `current_warp`.
- DONE: `done`=1 and `warp_enable`=0. Hold until `reset` or `start`.
- `warp_enable` = one-hot of `current_warp` in FETCH..UPDATE; 0 in IDLE and DONE.
- `warp_state` always shows the FSM phase (IDLE or DONE when idle).
- `start` in any state other than IDLE or DONE is ignored.

## Timing
- Reset values: phase IDLE, `fetch_req`=0, `warp_enable`=0, `warp_state`=WARP_IDLE, `current_warp`=0, `done`=0, `runnable`=0, `ret_q`=0, `mem_q`=0.
- Reset mid-instruction aborts immediately: no UPDATE is issued and all outputs return to their reset values next cycle.
- All outputs are registered; no combinational path from input to output.
- Best-case latency per instruction (`fetch_ready` in the first FETCH cycle, no memory op) is 6 cycles, FETCH through UPDATE.
- Memory op: add one cycle per WAIT cycle spent before `lsu_done`.
- Switching warps costs no bubble: UPDATE is followed directly by FETCH of the next warp.
- `start` to first FETCH: 1 cycle. Final UPDATE to `done`=1: 1 cycle.

## Structure
- Add to `common.sv`:
  - `warp_state_t`, including WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE and WARP_DONE.
  - A `NUM_WARPS` define.
- Sub-module `rr_next_warp`: purely combinational. Inputs are the runnable mask and the current index; outputs are the next index and a `found` flag.

## Test plan
- `NUM_WARPS`=4, start with `num_warps_active`=3, no memory ops, RET on the 2nd instruction of each warp:
  - Issue order is 0,1,2,0,1,2.
  - Each instruction takes 6 cycles.
  - `done`=1 exactly 1 cycle after the 6th UPDATE.
- Warp 1 issues a load; hold `lsu_done` low for 5 WAIT cycles:
  - Phase stays WAIT with `warp_enable`=4'b0010.
  - UPDATE comes 2 cycles after `lsu_done`.
  - A stray `lsu_done` pulse during EXECUTE has no effect.
- Delay `fetch_ready` by 3 cycles: `fetch_req` stays high for 4 cycles, then DECODE.
- Retire warps 0 and 2 early: the sole survivor, warp 1, reissues back-to-back as 1,1,1 with no IDLE gap.
- Launch edge cases:
  - `num_warps_active`=0 gives DONE on the next cycle.
  - `num_warps_active`=7 clamps to 4 warps.
  - `start` during EXECUTE is ignored.
- Assert `reset` during WAIT: next cycle all outputs are at reset values; a fresh `start` replays from warp 0.
